decoder_4to16: RTL and testbench
================================

// Module: decoder_4to16
// PURPOSE
//   Registered 4-to-16 one-hot decoder. Inputs A (LSB), B, C, D (MSB) form
//   code N = {D,C,B,A}; output O(N+1) is asserted, all others deasserted.
//   Used as a select/enable fan-out stage in front of 16-way banked logic.
//   Outputs are registered on one clock with asynchronous active-low reset.
// PARAMETERS
//   ACTIVE_LOW  0  1 = asserted output is 0 and idle outputs are 1; 0 = one-hot high
// PORTS
//   clk    in   1  system clock, all state updates on rising edge
//   rst_n  in   1  asynchronous active-low reset
//   en     in   1  decode enable; 0 forces all outputs idle
//   A      in   1  code bit 0 (LSB)
//   B      in   1  code bit 1
//   C      in   1  code bit 2
//   D      in   1  code bit 3 (MSB)
//   O1     out  1  asserted when code = 0 (O2 = code 1, ... O16 = code 15)
//   O2..O16 out 1  each one bit, O(k) asserted when code = k-1
//   valid  out  1  1 when O1..O16 hold a decoded code, 0 when idle
// BEHAVIOUR
//   - Clock/reset: one clock domain; rst_n is asynchronous, active-low.
//     rst_n=0 immediately forces O1..O16 to idle level (0 if ACTIVE_LOW=0,
//     1 if ACTIVE_LOW=1) and valid=0. Release is synchronised by the
//     integrating level; the block itself samples inputs from the first
//     rising clk edge with rst_n=1.
//   - Latency: 1 cycle. On rising clk edge with en=1, the registers load the
//     decode of the A..D values sampled at that edge; valid<=1.
//   - en=0 at a rising edge: all outputs go idle, valid<=0 (no hold).
//   - Exactly one output asserted whenever valid=1; zero asserted when valid=0.
//     The invariant holds on every cycle, including the first after reset.
//   - Input changes between edges have no effect on outputs (no glitches).
//   - X/Z on A..D with en=1: the registered output is all-idle and valid=0
//     (synthesis treats it as don't-care; simulation model must not emit
//     multi-hot).
//   - Index mapping fixed: N = 8*D + 4*C + 2*B + A; O(N+1) asserted.
//   - ACTIVE_LOW only inverts O1..O16; valid is always active-high.
//   - Reset asserted mid-operation clears outputs asynchronously, without
//     waiting for a clk edge; decoding resumes at the first edge after release.
// TESTING
//   1. rst_n=0 with A..D=1111, en=1 -> O1..O16=0, valid=0, no clk edge needed.
//   2. Release reset, en=1, sweep {D,C,B,A} 0000..1111 one value per cycle ->
//      one cycle later O(N+1)=1 only, valid=1; e.g. 0101 -> O6=1.
//   3. A toggles every 50ns, B 100ns, C 200ns, D 400ns, clk 10ns, en=1 ->
//      outputs step O1,O2,...,O16 in order with 1 cycle lag; exactly one hot.
//   4. en=1, code 1010 decoded (O11=1), then en=0 -> next edge all outputs 0,
//      valid=0; en=1 again -> O11=1 after one edge.
//   5. Code 0011 decoding (O4=1), assert rst_n=0 between edges -> O4 drops
//      immediately; after release first edge shows current code.
//   6. ACTIVE_LOW=1, code 0000 -> O1=0, O2..O16=1, valid=1; in reset all 1.

Source files
------------

// File: rtl/decoder_4to16.sv
// rtl/decoder_4to16.sv - registered 4-to-16 one-hot decoder with enable and valid
//
// Purpose : decodes code N = {D,C,B,A} into a single asserted output O(N+1),
//           registered on the rising clk edge, for use as a 16-way bank
//           select/enable fan-out stage.
// Params  : ACTIVE_LOW - 1: asserted output is 0 and idle outputs are 1
//                        0: one-hot high (asserted 1, idle 0)
// Ports   : clk       in  system clock, rising edge
//           rst_n     in  asynchronous active-low reset
//           en        in  decode enable; 0 forces all outputs idle
//           A,B,C,D   in  code bits, A = LSB, D = MSB
//           O1..O16   out O(k) asserted when code = k-1
//           valid     out 1 when O1..O16 hold a decoded code (always active-high)

module decoder_4to16 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic O1,
    output logic O2,
    output logic O3,
    output logic O4,
    output logic O5,
    output logic O6,
    output logic O7,
    output logic O8,
    output logic O9,
    output logic O10,
    output logic O11,
    output logic O12,
    output logic O13,
    output logic O14,
    output logic O15,
    output logic O16,
    output logic valid
);

    // XOR mask applied on the way out: the registers always hold one-hot-high
    // state, so reset to zero gives the correct idle level for either polarity.
    localparam logic [15:0] POLARITY_MASK = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    logic [3:0]  code;
    logic [15:0] onehot_d;
    logic [15:0] onehot_q;
    logic        valid_d;
    logic        valid_q;
    logic [15:0] o_vec;

    assign code = {D, C, B, A};

    // Explicit case items rather than a shift: an unknown code falls through
    // to the default and yields all-idle / valid=0 instead of a multi-hot X.
    always_comb begin
        onehot_d = 16'h0000;
        valid_d  = 1'b0;
        if (en) begin
            case (code)
                4'h0:    onehot_d = 16'h0001;
                4'h1:    onehot_d = 16'h0002;
                4'h2:    onehot_d = 16'h0004;
                4'h3:    onehot_d = 16'h0008;
                4'h4:    onehot_d = 16'h0010;
                4'h5:    onehot_d = 16'h0020;
                4'h6:    onehot_d = 16'h0040;
                4'h7:    onehot_d = 16'h0080;
                4'h8:    onehot_d = 16'h0100;
                4'h9:    onehot_d = 16'h0200;
                4'hA:    onehot_d = 16'h0400;
                4'hB:    onehot_d = 16'h0800;
                4'hC:    onehot_d = 16'h1000;
                4'hD:    onehot_d = 16'h2000;
                4'hE:    onehot_d = 16'h4000;
                4'hF:    onehot_d = 16'h8000;
                default: onehot_d = 16'h0000;
            endcase
            valid_d = |onehot_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_q <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    assign o_vec = onehot_q ^ POLARITY_MASK;
    assign valid = valid_q;

    assign O1  = o_vec[0];
    assign O2  = o_vec[1];
    assign O3  = o_vec[2];
    assign O4  = o_vec[3];
    assign O5  = o_vec[4];
    assign O6  = o_vec[5];
    assign O7  = o_vec[6];
    assign O8  = o_vec[7];
    assign O9  = o_vec[8];
    assign O10 = o_vec[9];
    assign O11 = o_vec[10];
    assign O12 = o_vec[11];
    assign O13 = o_vec[12];
    assign O14 = o_vec[13];
    assign O15 = o_vec[14];
    assign O16 = o_vec[15];

endmodule

// File: tb/tb_decoder_4to16.sv
// tb/tb_decoder_4to16.sv - directed self-checking bench for decoder_4to16

module tb_decoder_4to16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic A = 1'b0;
    logic B = 1'b0;
    logic C = 1'b0;
    logic D = 1'b0;

    logic [15:0] o_hi;
    logic [15:0] o_lo;
    logic        valid_hi;
    logic        valid_lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decoder_4to16 #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .C(C), .D(D),
        .O1(o_hi[0]),   .O2(o_hi[1]),   .O3(o_hi[2]),   .O4(o_hi[3]),
        .O5(o_hi[4]),   .O6(o_hi[5]),   .O7(o_hi[6]),   .O8(o_hi[7]),
        .O9(o_hi[8]),   .O10(o_hi[9]),  .O11(o_hi[10]), .O12(o_hi[11]),
        .O13(o_hi[12]), .O14(o_hi[13]), .O15(o_hi[14]), .O16(o_hi[15]),
        .valid(valid_hi)
    );

    decoder_4to16 #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .C(C), .D(D),
        .O1(o_lo[0]),   .O2(o_lo[1]),   .O3(o_lo[2]),   .O4(o_lo[3]),
        .O5(o_lo[4]),   .O6(o_lo[5]),   .O7(o_lo[6]),   .O8(o_lo[7]),
        .O9(o_lo[8]),   .O10(o_lo[9]),  .O11(o_lo[10]), .O12(o_lo[11]),
        .O13(o_lo[12]), .O14(o_lo[13]), .O15(o_lo[14]), .O16(o_lo[15]),
        .valid(valid_lo)
    );

    task automatic set_code(input logic [3:0] c);
        {D, C, B, A} = c;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        en = 1'b1;
        set_code(4'hF);
        #1;
        n_tests++;
        if (o_hi !== 16'h0000 || valid_hi !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_hi: O=%h valid=%b, required O=0000 valid=0", o_hi, valid_hi);
        end
        n_tests++;
        if (o_lo !== 16'hFFFF || valid_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_lo: O=%h valid=%b, required O=ffff valid=0", o_lo, valid_lo);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (o_hi !== 16'h0000 || valid_hi !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_edges: O=%h valid=%b, required O=0000 valid=0", o_hi, valid_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep;
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_code(4'(i));
            @(posedge clk);
            #1;
            exp = 16'h0001 << i;
            n_tests++;
            if (o_hi !== exp || valid_hi !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_code_%0d: O=%h valid=%b, required O=%h valid=1", i, o_hi, valid_hi, exp);
            end
        end
    endtask

    // A toggles every 50 ns (5 cycles), B every 100 ns, C 200 ns, D 400 ns:
    // the code counts up once every 5 cycles.
    task automatic test_toggle;
        logic [3:0]  code;
        logic [15:0] exp;
        int bad;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            code = 4'((k / 5) % 16);
            set_code(code);
            @(posedge clk);
            #1;
            exp = 16'h0001 << code;
            if (o_hi !== exp || $countones(o_hi) != 1 || valid_hi !== 1'b1) begin
                if (bad == 0)
                    $display("FAIL toggle_step_%0d: O=%h valid=%b, required O=%h valid=1", k, o_hi, valid_hi, exp);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_enable;
        @(negedge clk);
        en = 1'b1;
        set_code(4'b1010);
        @(posedge clk);
        #1;
        n_tests++;
        if (o_hi !== 16'h0400 || valid_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_decode: O=%h valid=%b, required O=0400 valid=1", o_hi, valid_hi);
        end
        #1 set_code(4'b0001);
        #1;
        n_tests++;
        if (o_hi !== 16'h0400) begin
            n_fail++;
            $display("FAIL between_edges: O=%h, required O=0400", o_hi);
        end
        @(negedge clk);
        set_code(4'b1010);
        en = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (o_hi !== 16'h0000 || valid_hi !== 1'b0 || o_lo !== 16'hFFFF || valid_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_off: O=%h valid=%b Olo=%h validlo=%b, required 0000/0 ffff/0",
                     o_hi, valid_hi, o_lo, valid_lo);
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (o_hi !== 16'h0400 || valid_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_resume: O=%h valid=%b, required O=0400 valid=1", o_hi, valid_hi);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        set_code(4'b0011);
        @(posedge clk);
        #1;
        n_tests++;
        if (o_hi !== 16'h0008 || valid_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: O=%h valid=%b, required O=0008 valid=1", o_hi, valid_hi);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_hi !== 16'h0000 || valid_hi !== 1'b0) begin
            n_fail++;
            $display("FAIL async_mid_cycle: O=%h valid=%b, required O=0000 valid=0", o_hi, valid_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_code(4'b0110);
        @(posedge clk);
        #1;
        n_tests++;
        if (o_hi !== 16'h0040 || valid_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: O=%h valid=%b, required O=0040 valid=1", o_hi, valid_hi);
        end
    endtask

    task automatic test_active_low;
        @(negedge clk);
        set_code(4'b0000);
        @(posedge clk);
        #1;
        n_tests++;
        if (o_lo !== 16'hFFFE || valid_lo !== 1'b1) begin
            n_fail++;
            $display("FAIL active_low_code0: O=%h valid=%b, required O=fffe valid=1", o_lo, valid_lo);
        end
        @(negedge clk);
        set_code(4'b0101);
        @(posedge clk);
        #1;
        n_tests++;
        if (o_lo !== 16'hFFDF || valid_lo !== 1'b1) begin
            n_fail++;
            $display("FAIL active_low_code5: O=%h valid=%b, required O=ffdf valid=1", o_lo, valid_lo);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_lo !== 16'hFFFF || valid_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL active_low_reset: O=%h valid=%b, required O=ffff valid=0", o_lo, valid_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_toggle();
        test_enable();
        test_async_reset();
        test_active_low();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
